model_test_sdiv_18s_6s_12_seq: RTL and testbench
================================================

MODEL_TEST_SDIV_18S_6S_12_SEQ -- requirements
Module: model_test_sdiv_18s_6s_12_seq

Interface
REQ-001 Parameter ID, default 1, instance identifier; no functional effect.
REQ-002 Parameter din0_WIDTH, default 18, dividend width (signed).
REQ-003 Parameter din1_WIDTH, default 6, divisor and remainder width (signed).
REQ-004 Parameter dout_WIDTH, default 12, quotient width (signed).
REQ-005 The block SHALL use one clock, ap_clk; reset ap_rst is asynchronous and active-high.
REQ-006 ap_clk  input  1  clock, all state updates on rising edge.
REQ-007 ap_rst  input  1  asynchronous active-high reset.
REQ-008 ce  input  1  clock enable; low freezes all state and outputs.
REQ-009 start  input  1  request to begin a division; sampled only in IDLE with ce=1.
REQ-010 din0  input  din0_WIDTH  signed dividend, captured on accepted start.
REQ-011 din1  input  din1_WIDTH  signed divisor, captured on accepted start.
REQ-012 idle  output  1  high while in IDLE (ready to accept start).
REQ-013 done  output  1  result-valid pulse.
REQ-014 quot  output  dout_WIDTH  signed quotient, registered.
REQ-015 rem  output  din1_WIDTH  signed remainder, registered.

Function
REQ-016 The block SHALL implement states IDLE, CALC, DONE; a transition occurs only on a rising edge with ce=1.
REQ-017 IDLE -> CALC when start=1; operands captured, signs recorded, magnitudes formed (|din0| in din0_WIDTH+1 bits to hold |-2^(din0_WIDTH-1)|).
REQ-018 CALC SHALL perform one restoring shift-subtract step per enabled cycle, for exactly din0_WIDTH steps, then go to DONE.
REQ-019 DONE SHALL last exactly one enabled cycle, then return to IDLE; done=1 only in DONE.
REQ-020 Latency: with ce held high, done SHALL be high on the din0_WIDTH+1-th rising edge after the edge accepting start (19 cycles by default).
REQ-021 Each low-ce cycle SHALL extend latency by one cycle; if ce is low while in DONE, done stays high until the next enabled edge.
REQ-022 start while not in IDLE SHALL be ignored; no queuing.
REQ-023 Quotient SHALL be truncated toward zero; negated when operand signs differ; quot = low dout_WIDTH bits of the exact quotient (overflow wraps silently).
REQ-024 Remainder SHALL take the sign of the dividend, |rem| < |divisor|, and satisfy din0 = q*din1 + rem before truncation.
REQ-025 Divisor zero: full latency retained; quot = all ones; rem = low din1_WIDTH bits of din0.
REQ-026 quot and rem SHALL update only on the edge entering DONE and hold until the next entry into DONE.
REQ-027 Captured operands SHALL be unaffected by din0/din1 changes after acceptance.

Reset
REQ-028 ap_rst=1 SHALL immediately force state IDLE, idle=1, done=0, quot=0, rem=0, internal datapath cleared, independent of ap_clk and ce.
REQ-029 Reset during CALC or DONE SHALL abort the operation with no done pulse; the first enabled edge after release may accept start.

Verification
REQ-030 din0=100, din1=7, start one cycle, ce=1 -> done on edge 19 only, quot=0x00E, rem=0x02, idle high again next cycle.
REQ-031 Sign matrix: -100/7 -> quot=0xFF2, rem=0x3E; 100/-7 -> quot=0xFF2, rem=0x02; -100/-7 -> quot=0x00E, rem=0x3E; 1000/-32 -> quot=0xFE1, rem=0x08.
REQ-032 Divide by zero: 55/0 -> done on edge 19, quot=0xFFF, rem=0x37; overflow -131072/1 -> quot=0x000, rem=0x00.
REQ-033 ce low for 5 cycles mid-CALC, 100/7 -> done on edge 24, same results; start pulses during CALC -> ignored, single done.
REQ-034 ap_rst asserted asynchronously at cycle 10 of CALC -> outputs 0 and idle=1 before the next edge, no done; then 100/7 completes normally.

Source files
------------

// File: rtl/model_test_sdiv_18s_6s_12_seq.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per enabled cycle, with the sign fix-up applied on the way into DONE.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; idle=1
// CALC  | din0_WIDTH shift-subtract steps, then one cycle to finalize
// DONE  | quot/rem valid, done=1 for exactly one enabled cycle
module model_test_sdiv_18s_6s_12_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 18,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 12
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         ce,
    input  logic                         start,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    output logic                         idle,
    output logic                         done,
    output logic signed [dout_WIDTH-1:0] quot,
    output logic signed [din1_WIDTH-1:0] rem
);

    localparam int CW = $clog2(din0_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    // Magnitudes are held unsigned: the most negative dividend (-2^(N-1))
    // negates to 2^(N-1), which is exact as an N-bit unsigned value, so the
    // extra magnitude bit never needs to be stored.
    logic [din0_WIDTH-1:0] dvd;
    logic [din1_WIDTH-1:0] dvs;
    logic [din1_WIDTH-1:0] part;
    logic [din1_WIDTH-1:0] dvd_low;
    logic                  neg_q;
    logic                  neg_r;
    logic                  div_zero;

    logic [din1_WIDTH:0]   trial;
    logic                  fits;
    logic [din1_WIDTH-1:0] part_next;

    // One restoring step: bring in the next dividend bit, subtract the divisor if it fits.
    always_comb begin
        trial     = {part, dvd[din0_WIDTH-1]};
        fits      = (trial >= {1'b0, dvs});
        part_next = fits ? din1_WIDTH'(trial - {1'b0, dvs}) : trial[din1_WIDTH-1:0];
    end

    // Sequencing FSM with datapath and registered outputs; ce low freezes everything.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            part     <= '0;
            dvd_low  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            idle     <= 1'b1;
            done     <= 1'b0;
            quot     <= '0;
            rem      <= '0;
        end else if (ce) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_CALC;
                        cnt      <= CW'(din0_WIDTH);
                        dvd      <= $unsigned(din0[din0_WIDTH-1] ? -din0 : din0);
                        dvs      <= $unsigned(din1[din1_WIDTH-1] ? -din1 : din1);
                        part     <= '0;
                        dvd_low  <= din0[din1_WIDTH-1:0];
                        neg_q    <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                        neg_r    <= din0[din0_WIDTH-1];
                        div_zero <= (din1 == '0);
                        idle     <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (cnt != '0) begin
                        cnt  <= cnt - 1'b1;
                        dvd  <= {dvd[din0_WIDTH-2:0], fits};
                        part <= part_next;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        quot  <= div_zero ? '1 : dout_WIDTH'(neg_q ? -dvd : dvd);
                        rem   <= div_zero ? dvd_low : (neg_r ? -part : part);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    idle  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_model_test_sdiv_18s_6s_12_seq.sv
// Bench for the sequential signed divider: directed corner cases plus random
// operands, compared against integer division in the bench.
module tb_model_test_sdiv_18s_6s_12_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        ce     = 1'b0;
    logic        start  = 1'b0;
    logic [17:0] din0   = '0;
    logic [5:0]  din1   = '0;
    logic        idle;
    logic        done;
    logic [11:0] quot;
    logic [5:0]  rem;

    int n_cmp = 0;
    int n_err = 0;

    model_test_sdiv_18s_6s_12_seq #(
        .ID(1), .din0_WIDTH(18), .din1_WIDTH(6), .dout_WIDTH(12)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .start(start),
        .din0(din0), .din1(din1), .idle(idle), .done(done),
        .quot(quot), .rem(rem)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: C-style truncating division; remainder follows the dividend.
    function automatic void ref_div(input int a, input int b,
                                    output logic [11:0] q, output logic [5:0] r);
        int qi, ri;
        if (b == 0) begin
            q  = 12'hFFF;
            ri = a;
            r  = ri[5:0];
        end else begin
            qi = a / b;
            ri = a % b;
            q  = qi[11:0];
            r  = ri[5:0];
        end
    endfunction

    // Starts one division from posedge+1 and follows it to completion.
    task automatic run_div(input int a, input int b, input int stall_at, input int stall_len,
                           input bit poke, input int hold);
        logic [11:0] eq;
        logic [5:0]  er;
        int lat, ndone, exp_lat;
        ref_div(a, b, eq, er);
        exp_lat = 19 + stall_len;
        din0  = a[17:0];
        din1  = b[5:0];
        start = 1'b1;
        ce    = 1'b1;
        @(posedge ap_clk); #1;
        start = 1'b0;
        din0  = 18'($urandom);
        din1  = 6'($urandom);
        check("idle_busy", {31'b0, idle}, 32'd0);
        lat   = -1;
        ndone = 0;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            ce = !(stall_len > 0 && n >= stall_at && n < stall_at + stall_len);
            if (poke) start = 1'($urandom_range(0, 1));
            @(posedge ap_clk); #1;
            if (done) begin
                lat = n;
                ndone++;
            end
        end
        start = 1'b0;
        check("latency", lat, exp_lat);
        check("quot", {20'b0, quot}, {20'b0, eq});
        check("rem", {26'b0, rem}, {26'b0, er});
        for (int h = 0; h < hold; h++) begin
            ce = 1'b0;
            @(posedge ap_clk); #1;
            if (done) ndone++;
            check("done_hold", {31'b0, done}, 32'd1);
        end
        ce = 1'b1;
        @(posedge ap_clk); #1;
        if (done) ndone++;
        check("done_count", ndone, 1 + hold);
        check("idle_after", {31'b0, idle}, 32'd1);
        check("quot_hold", {20'b0, quot}, {20'b0, eq});
    endtask

    initial begin
        int a, b, sa, sl;
        #12;
        check("rst_idle", {31'b0, idle}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_quot", {20'b0, quot}, 32'd0);
        check("rst_rem", {26'b0, rem}, 32'd0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        ce     = 1'b1;

        run_div(100, 7, 0, 0, 1'b0, 0);
        run_div(-100, 7, 0, 0, 1'b0, 0);
        run_div(100, -7, 0, 0, 1'b0, 0);
        run_div(-100, -7, 0, 0, 1'b0, 0);
        run_div(1000, -32, 0, 0, 1'b0, 0);
        run_div(55, 0, 0, 0, 1'b0, 0);
        run_div(-131072, 1, 0, 0, 1'b0, 0);
        run_div(131071, -32, 0, 0, 1'b0, 0);
        run_div(100, 7, 5, 5, 1'b0, 0);
        run_div(100, 7, 0, 0, 1'b1, 0);
        run_div(-100, 7, 0, 0, 1'b0, 2);

        // Asynchronous reset in the middle of CALC.
        din0  = 18'd100;
        din1  = 6'd7;
        start = 1'b1;
        @(posedge ap_clk); #1;
        start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge ap_clk); #1;
        end
        #2 ap_rst = 1'b1;
        #1;
        check("arst_idle", {31'b0, idle}, 32'd1);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_quot", {20'b0, quot}, 32'd0);
        check("arst_rem", {26'b0, rem}, 32'd0);
        for (int n = 0; n < 12; n++) begin
            @(posedge ap_clk); #1;
            check("arst_nodone", {31'b0, done}, 32'd0);
        end
        ap_rst = 1'b0;
        run_div(100, 7, 0, 0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 262143)) - 131072;
            b = int'($urandom_range(0, 63)) - 32;
            if (i % 10 == 3) b = 0;
            if (i % 10 == 7) a = -131072;
            sl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            sa = int'($urandom_range(1, 15));
            run_div(a, b, sa, sl, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
